rsa_job_arbiter: RTL and testbench
==================================

RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4096, the operand and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 32'd16000000, the maximum number of core cycles per job before abort.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  the requester has a job pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  the job is accepted this cycle.
REQ-007 SHALL have ports reqN_message, reqN_exponent, reqN_modulus (N=0,1)  input  WIDTH each  the job operands.
REQ-008 SHALL have ports rsp_valid  output  1 and rsp_ready  input  1  the response handshake.
REQ-009 SHALL have ports rsp_id  output  1 (the requester index), rsp_err  output  1 (the job failed), and rsp_data  output  WIDTH (the result).
REQ-010 SHALL have ports core_go  output  1, core_reset  output  1, core_message/core_exponent/core_modulus  output  WIDTH each, core_cypher  input  WIDTH, and core_done  input  1.

Function
REQ-011 SHALL implement the states IDLE, LAUNCH, BUSY, FLUSH and RESP.
REQ-012 In IDLE, SHALL grant one valid requester by round-robin; when both are valid, the grant goes to the requester not granted last; last_grant resets to 1, so req0 wins first.
REQ-013 SHALL assert reqN_ready for exactly one cycle, in IDLE, to the granted requester only; SHALL latch its operands and index on that edge.
REQ-014 If the latched modulus is even (including zero), SHALL skip the core and go to RESP with rsp_err=1 and rsp_data=0.
REQ-015 Otherwise SHALL go to LAUNCH and drive core_go=1 from LAUNCH through BUSY; core_message, core_exponent and core_modulus SHALL hold the latched operands stable for the whole job.
REQ-016 In BUSY, on core_done=1, SHALL capture core_cypher into rsp_data, drop core_go on the next cycle, and go to RESP with rsp_err=0.
REQ-017 SHALL count cycles in LAUNCH and BUSY with a 32-bit counter; on reaching TIMEOUT without core_done, SHALL go to FLUSH.
REQ-018 In FLUSH, SHALL hold core_go=0 and core_reset=1 for exactly 2 cycles, then go to RESP with rsp_err=1 and rsp_data=0.
REQ-019 In RESP, SHALL hold rsp_valid=1 with stable rsp_id, rsp_err and rsp_data until rsp_ready=1; after that handshake, SHALL go to IDLE.
REQ-020 SHALL keep core_go low for at least 1 cycle between consecutive jobs, because IDLE is always visited.
REQ-021 SHALL ignore core_done outside BUSY.
REQ-022 SHALL leave requester valid signals that drop without a grant unacknowledged, with no state effect.
REQ-023 SHALL update last_grant only on a grant, including jobs later rejected for an even modulus.
REQ-024 Accepted-job latency to rsp_valid SHALL be core latency + 2 cycles; for a rejected modulus it SHALL be 1 cycle.

Reset
REQ-025 On reset, SHALL force the state to IDLE and clear the counter.
REQ-026 On reset, SHALL drive every ready/valid output, core_go, core_reset, rsp_err and rsp_id to 0, and the operand registers and rsp_data to 0, with last_grant=1.
REQ-027 Reset asserted mid-job SHALL abandon the job without a response; the core is reset by the system reset, not by core_reset.

Structure
REQ-028 SHALL place the state encoding, the default TIMEOUT and the FLUSH length (2) in a shared package, rsa_pkg.
REQ-029 SHALL contain one sub-module, rr_arbiter2, a 2-way round-robin grant with last_grant state; the core is instantiated outside this block.

Verification
REQ-030 Scenario: req0 with message 8, exponent 13, modulus 77 -> core_go high until core_done; rsp_id=0, rsp_err=0, rsp_data=50.
REQ-031 Scenario: req1 with message 50, exponent 37, modulus 77 -> rsp_id=1, rsp_data=8.
REQ-032 Scenario: both valid in the same cycle, repeated 4 jobs -> grant order 0,1,0,1; core_go low at least 1 cycle between jobs.
REQ-033 Scenario: modulus 76 -> no core_go pulse; rsp_err=1, rsp_data=0 one cycle after the grant.
REQ-034 Scenario: stub core never asserting done, TIMEOUT=100 -> core_reset high for 2 cycles after cycle 100, then rsp_err=1.
REQ-035 Scenario: rsp_ready held low 20 cycles, then reset asserted mid-BUSY -> response outputs stable while stalled; after reset all outputs 0 and state IDLE, with the next grant to req0.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job arbiter: FSM state encoding,
// default abort timeout and the length of the core flush sequence.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_BUSY   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic [31:0] DEFAULT_TIMEOUT = 32'd16000000;
  localparam int unsigned FLUSH_LEN       = 2;
  localparam int unsigned FLUSH_CNT_W     = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. When both requesters are valid the one not
// granted last wins; last_grant only moves when a grant is actually taken.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic advance_i,
  output logic grant0_o,
  output logic grant1_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant0_o = valid0_i & (~valid1_i | last_q);
    grant1_o = valid1_i & (~valid0_i | ~last_q);
    last_d   = last_q;
    if (advance_i & (grant0_o | grant1_o)) begin
      last_d = grant1_o;
    end
  end

  // Reset value 1 makes requester 0 win the first contested grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Arbitrates two requesters onto one modular-exponentiation core, guards the
// core with a cycle timeout plus flush, and returns one response per job.
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH   = 4096,
  parameter logic [31:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_message,
  input  logic [WIDTH-1:0] req0_exponent,
  input  logic [WIDTH-1:0] req0_modulus,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_message,
  input  logic [WIDTH-1:0] req1_exponent,
  input  logic [WIDTH-1:0] req1_modulus,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             core_go,
  output logic             core_reset,
  output logic [WIDTH-1:0] core_message,
  output logic [WIDTH-1:0] core_exponent,
  output logic [WIDTH-1:0] core_modulus,
  input  logic [WIDTH-1:0] core_cypher,
  input  logic             core_done
);

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
  logic [WIDTH-1:0]       msg_q, exp_q, mod_q;
  logic                   id_q;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rsp_load;
  logic                   grant0, grant1, take;
  logic [WIDTH-1:0]       sel_modulus;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .advance_i (take),
    .grant0_o  (grant0),
    .grant1_o  (grant1)
  );

  assign take        = (state_q == ST_IDLE) & (grant0 | grant1);
  assign sel_modulus = grant1 ? req1_modulus : req0_modulus;

  assign req0_ready    = (state_q == ST_IDLE) & grant0 & ~reset;
  assign req1_ready    = (state_q == ST_IDLE) & grant1 & ~reset;
  assign core_go       = (state_q == ST_LAUNCH) | (state_q == ST_BUSY);
  assign core_reset    = (state_q == ST_FLUSH);
  assign core_message  = msg_q;
  assign core_exponent = exp_q;
  assign core_modulus  = mod_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = id_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_data      = rsp_data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    flush_d    = '0;
    rsp_load   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          // An even modulus cannot be handled by the core; reject at once.
          if (!sel_modulus[0]) begin
            state_d   = ST_RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = cnt_q + 32'd1;
        state_d = (cnt_d >= TIMEOUT) ? ST_FLUSH : ST_BUSY;
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d    = ST_RESP;
          rsp_load   = 1'b1;
          rsp_data_d = core_cypher;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d >= TIMEOUT) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_CNT_W'(FLUSH_LEN - 1)) begin
          state_d   = ST_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Operands stay latched after the job so the core inputs never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q      <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (take) begin
        msg_q <= grant1 ? req1_message  : req0_message;
        exp_q <= grant1 ? req1_exponent : req0_exponent;
        mod_q <= sel_modulus;
        id_q  <= grant1;
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Randomized bench for rsa_job_arbiter with a behavioural stub core and a
// job-level reference model (round-robin owner, modexp result, latency).
module tb_rsa_job_arbiter;

  localparam int          W   = 16;
  localparam logic [31:0] TMO = 32'd100;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_message, req0_exponent, req0_modulus;
  logic [W-1:0] req1_message, req1_exponent, req1_modulus;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         core_go, core_reset, core_done;
  logic [W-1:0] core_message, core_exponent, core_modulus, core_cypher;

  int n_cmp = 0;
  int n_bad = 0;
  int model_last = 1;
  int job_no = 0;
  int stub_lat = 1;
  bit stub_hang = 1'b0;
  int core_cnt;

  rsa_job_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_message  (req0_message),
    .req0_exponent (req0_exponent),
    .req0_modulus  (req0_modulus),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_message  (req1_message),
    .req1_exponent (req1_exponent),
    .req1_modulus  (req1_modulus),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .rsp_data      (rsp_data),
    .core_go       (core_go),
    .core_reset    (core_reset),
    .core_message  (core_message),
    .core_exponent (core_exponent),
    .core_modulus  (core_modulus),
    .core_cypher   (core_cypher),
    .core_done     (core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    longint r, x, nn;
    if (n == '0) return '0;
    nn = longint'(n);
    r  = 1 % nn;
    x  = longint'(b) % nn;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[W-1:0];
  endfunction

  // Stub core: done pulses stub_lat cycles after core_go rises; while idle it
  // emits random spurious done pulses with garbage data.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt    <= 0;
      core_done   <= 1'b0;
      core_cypher <= '0;
    end else if (core_go && !core_reset) begin
      core_cnt    <= core_cnt + 1;
      core_done   <= !stub_hang && (core_cnt + 1 == stub_lat);
      core_cypher <= modexp(core_message, core_exponent, core_modulus);
    end else begin
      core_cnt    <= 0;
      core_done   <= ($urandom_range(0, 3) == 0);
      core_cypher <= W'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 0);
    check_eq({tag, "_rsp"}, {29'd0, rsp_valid, rsp_err, rsp_id}, 0);
    check_eq({tag, "_data"}, 32'(rsp_data), 0);
    check_eq({tag, "_core"}, {30'd0, core_go, core_reset}, 0);
    check_eq({tag, "_ops"}, 32'(core_message | core_exponent | core_modulus), 0);
  endtask

  task automatic run_job(input logic v0, input logic v1,
                         input logic [W-1:0] m0, input logic [W-1:0] e0, input logic [W-1:0] n0,
                         input logic [W-1:0] m1, input logic [W-1:0] e1, input logic [W-1:0] n1,
                         input int lat, input bit hang, input int stall, input int abort_at);
    int exp_id, exp_lat, exp_go, exp_rst, cyc, go_cnt, rst_cnt;
    logic [W-1:0] em, ee, en, exp_data;
    bit exp_err;
    stub_lat  = lat;
    stub_hang = hang;
    @(negedge clk);
    req0_valid = v0; req0_message = m0; req0_exponent = e0; req0_modulus = n0;
    req1_valid = v1; req1_message = m1; req1_exponent = e1; req1_modulus = n1;
    if (v0 && v1) exp_id = 1 - model_last;
    else          exp_id = v1 ? 1 : 0;
    model_last = exp_id;
    em = exp_id ? m1 : m0;
    ee = exp_id ? e1 : e0;
    en = exp_id ? n1 : n0;
    if (!en[0]) begin
      exp_err = 1'b1; exp_data = '0; exp_lat = 1; exp_go = 0; exp_rst = 0;
    end else if (hang) begin
      exp_err = 1'b1; exp_data = '0; exp_lat = int'(TMO) + 3; exp_go = int'(TMO); exp_rst = 2;
    end else begin
      exp_err = 1'b0; exp_data = modexp(em, ee, en); exp_lat = lat + 2; exp_go = lat + 1; exp_rst = 0;
    end
    #1;
    check_eq("grant", {30'd0, req1_ready, req0_ready}, (exp_id == 1) ? 2 : 1);
    check_eq("go_gap", {31'd0, core_go}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc = 1; go_cnt = 0; rst_cnt = 0;
    while (!rsp_valid && cyc < 400) begin
      if (cyc == 1) begin
        check_eq("core_msg", 32'(core_message), 32'(em));
        check_eq("core_exp", 32'(core_exponent), 32'(ee));
        check_eq("core_mod", 32'(core_modulus), 32'(en));
        // Requests arriving mid-job must not be acknowledged.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("ready_busy", {30'd0, req1_ready, req0_ready}, 0);
      end
      if (cyc == 2) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        check_eq("busy_pre_rst", {31'd0, core_go}, 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        model_last = 1;
        @(negedge clk);
        reset = 1'b0;
        $display("job %0d id=%0d aborted by reset at cycle %0d", job_no, exp_id, cyc);
        job_no++;
        return;
      end
      go_cnt  += int'(core_go);
      rst_cnt += int'(core_reset);
      @(negedge clk);
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("latency", cyc, exp_lat);
    check_eq("go_cycles", go_cnt, exp_go);
    check_eq("flush_cycles", rst_cnt, exp_rst);
    for (int s = 0; s <= stall; s++) begin
      check_eq("rsp_valid", {31'd0, rsp_valid}, 1);
      check_eq("rsp_id", {31'd0, rsp_id}, exp_id);
      check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
      if (s < stall) @(negedge clk);
    end
    $display("job %0d id=%0d err=%0d data=%0h lat=%0d stall=%0d", job_no, rsp_id, rsp_err,
             rsp_data, cyc, stall);
    job_no++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", {31'd0, rsp_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r_m0, r_e0, r_n0, r_m1, r_e1, r_n1;
    int sel;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_message = '0; req0_exponent = '0; req0_modulus = '0;
    req1_message = '0; req1_exponent = '0; req1_modulus = '0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;

    run_job(1'b1, 1'b0, 16'd8, 16'd13, 16'd77, 16'd0, 16'd0, 16'd0, 5, 1'b0, 1, 0);
    run_job(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd50, 16'd37, 16'd77, 3, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      run_job(1'b1, 1'b1, 16'd8, 16'd13, 16'd77, 16'd50, 16'd37, 16'd77, 2 + k, 1'b0, 0, 0);
    end
    run_job(1'b1, 1'b0, 16'd8, 16'd13, 16'd76, 16'd0, 16'd0, 16'd0, 4, 1'b0, 2, 0);
    run_job(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd9, 16'd5, 16'd91, 1, 1'b1, 1, 0);
    run_job(1'b1, 1'b0, 16'd123, 16'd45, 16'd1001, 16'd0, 16'd0, 16'd0, 4, 1'b0, 20, 0);
    run_job(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd7, 16'd11, 16'd143, 60, 1'b0, 0, 5);
    run_job(1'b1, 1'b1, 16'd3, 16'd7, 16'd33, 16'd5, 16'd9, 16'd35, 2, 1'b0, 0, 0);

    for (int j = 0; j < 40; j++) begin
      sel  = $urandom_range(1, 3);
      r_m0 = W'($urandom); r_e0 = W'($urandom); r_n0 = W'($urandom);
      r_m1 = W'($urandom); r_e1 = W'($urandom); r_n1 = W'($urandom);
      if ($urandom_range(0, 3) != 0) r_n0[0] = 1'b1;
      if ($urandom_range(0, 3) != 0) r_n1[0] = 1'b1;
      run_job(sel[0] ? 1'b1 : 1'b0, sel[1] ? 1'b1 : 1'b0, r_m0, r_e0, r_n0, r_m1, r_e1, r_n1,
              $urandom_range(1, 15), ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
